mem_access_unit: RTL and testbench

- Consumer side of the execute-stage result bus: takes the EX/MEM register contents (ALU result, zero flag, forwarded funct3, itype, store data, rd).
- Performs data-memory loads and stores over a ready-handshaked memory port and resolves BEQ/BNE using the zero flag.
- Presents a registered writeback packet to the MEM/WB register and stalls upstream while a memory access is outstanding.

---
 rtl/mem_access_unit.sv | 183 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory-access stage: resolves branches, runs loads/stores over a ready-handshaked
// port with a wait timeout, and emits a registered one-cycle writeback packet.
module mem_access_unit #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  itype,
   input  logic [31:0] alu_out,
   input  logic        zero,
   input  logic [2:0]  funct3,
   input  logic [31:0] store_data,
   input  logic [4:0]  rd,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic        wb_valid,
   output logic        wb_we,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        wb_err,
   output logic        branch_taken
);

   localparam logic [2:0] IT_LOAD   = 3'b000;
   localparam logic [2:0] IT_ITYPE  = 3'b001;
   localparam logic [2:0] IT_STORE  = 3'b010;
   localparam logic [2:0] IT_RTYPE  = 3'b011;
   localparam logic [2:0] IT_BRANCH = 3'b110;
   localparam logic [7:0] TMAX      = 8'(TIMEOUT - 1);

   typedef enum logic {S_IDLE, S_ACCESS} state_t;

   state_t      state, state_nxt;
   logic [7:0]  tcnt;
   logic        load_q;
   logic [2:0]  funct3_q;
   logic [31:0] alu_q;
   logic [4:0]  rd_q;

   logic        accept, is_load, is_store, mem_op, f3_legal, misalign, mem_go;
   logic        done, abort, branch_in, reg_write_in;
   logic [3:0]  be_in;
   logic [31:0] wdata_in, lane, load_val;

   assign accept    = in_valid && in_ready;
   assign is_load   = (itype == IT_LOAD);
   assign is_store  = (itype == IT_STORE);
   assign mem_op    = is_load || is_store;
   assign f3_legal  = is_load ? (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                              : (is_store && (funct3 inside {3'b000, 3'b001, 3'b010}));
   assign misalign  = ((funct3[1:0] == 2'b01) && alu_out[0]) ||
                      ((funct3[1:0] == 2'b10) && (alu_out[1:0] != 2'b00));
   assign mem_go    = mem_op && f3_legal && !misalign;
   assign branch_in = (itype == IT_BRANCH) &&
                      (((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero));
   assign reg_write_in = ((itype == IT_RTYPE) || (itype == IT_ITYPE)) && (rd != 5'd0);

   // mem_req is only high in ACCESS, so mem_ready alone marks completion there.
   assign done  = (state == S_ACCESS) && mem_ready;
   assign abort = (state == S_ACCESS) && !mem_ready && (tcnt == TMAX);

   always_comb begin
      be_in    = 4'b1111;
      wdata_in = store_data;
      case (funct3[1:0])
         2'b00: begin
            be_in    = 4'b0001 << alu_out[1:0];
            wdata_in = {4{store_data[7:0]}};
         end
         2'b01: begin
            be_in    = 4'b0011 << {alu_out[1], 1'b0};
            wdata_in = {2{store_data[15:0]}};
         end
         default: ;
      endcase
   end

   // Accesses are aligned, so shifting by the byte offset puts the addressed lane at bit 0.
   assign lane = mem_rdata >> {alu_q[1:0], 3'b000};

   always_comb begin
      case (funct3_q)
         3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
         3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
         3'b100:  load_val = {24'b0, lane[7:0]};
         3'b101:  load_val = {16'b0, lane[15:0]};
         default: load_val = lane;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // NOTE: every output of this process gets a default before the case, so no latch is inferred.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (accept && mem_go) state_nxt = S_ACCESS;
         end
         S_ACCESS: begin
            if (done || abort) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; the leading defaults make the
   // writeback flags single-cycle pulses.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_be       <= '0;
         mem_wdata    <= '0;
         wb_valid     <= 1'b0;
         wb_we        <= 1'b0;
         wb_rd        <= '0;
         wb_data      <= '0;
         wb_err       <= 1'b0;
         branch_taken <= 1'b0;
         tcnt         <= '0;
         load_q       <= 1'b0;
         funct3_q     <= '0;
         alu_q        <= '0;
         rd_q         <= '0;
      end else begin
         wb_valid     <= 1'b0;
         wb_we        <= 1'b0;
         wb_err       <= 1'b0;
         branch_taken <= 1'b0;
         if (accept) begin
            if (mem_go) begin
               mem_req   <= 1'b1;
               mem_we    <= is_store;
               mem_addr  <= {alu_out[31:2], 2'b00};
               mem_be    <= be_in;
               mem_wdata <= wdata_in;
               load_q    <= is_load;
               funct3_q  <= funct3;
               alu_q     <= alu_out;
               rd_q      <= rd;
               tcnt      <= '0;
            end else begin
               // Non-memory packets and rejected memory packets write back straight away.
               wb_valid     <= 1'b1;
               wb_rd        <= rd;
               wb_data      <= alu_out;
               wb_we        <= reg_write_in;
               wb_err       <= mem_op;
               branch_taken <= branch_in;
            end
         end else if (done) begin
            mem_req  <= 1'b0;
            wb_valid <= 1'b1;
            wb_rd    <= rd_q;
            wb_data  <= load_q ? load_val : alu_q;
            wb_we    <= load_q && (rd_q != 5'd0);
         end else if (abort) begin
            mem_req  <= 1'b0;
            wb_valid <= 1'b1;
            wb_err   <= 1'b1;
            wb_rd    <= rd_q;
            wb_data  <= alu_q;
         end else if (state == S_ACCESS) begin
            tcnt <= tcnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: transaction-level reference model, per-cycle compare
// process, directed scenarios with literal expectations, then randomized traffic.
module tb_mem_access_unit;

   localparam int TO = 4;

   typedef struct {
      int          cyc;
      logic [31:0] data;
      logic [4:0]  rd;
      logic        we;
      logic        err;
      logic        bt;
      bit          chk_data;
   } wb_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid, in_ready;
   logic [2:0]  itype, funct3;
   logic [31:0] alu_out, store_data;
   logic        zero;
   logic [4:0]  rd;
   logic        mem_req, mem_we, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;
   logic        wb_valid, wb_we, wb_err, branch_taken;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   wb_t exp_q[$];
   wb_t obs_q[$];
   int  acc_s = -1;
   int  acc_e = -1;
   logic [31:0] acc_addr, acc_wdata;
   logic [3:0]  acc_be;
   logic        acc_we;

   logic [31:0] obs_addr, obs_wdata;
   logic [3:0]  obs_be;
   logic        obs_mwe;
   int          req_run = 0;
   int          req_cycles = 0;
   int          req_total = 0;
   logic [31:0] last_data = '0;
   logic [4:0]  last_rd = '0;
   bit          hold_known = 1'b1;
   bit          exp_req;
   wb_t         ce, co;

   mem_access_unit #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .itype(itype), .alu_out(alu_out), .zero(zero), .funct3(funct3),
      .store_data(store_data), .rd(rd), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .wb_valid(wb_valid),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .wb_err(wb_err),
      .branch_taken(branch_taken)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: what one packet must produce, from the instruction-level rules.
   function automatic void model(input logic [2:0] it, input logic [2:0] f3, input logic [31:0] a,
                                 input logic z, input logic [31:0] sd, input logic [4:0] r,
                                 input logic [31:0] rdata, output bit go, output logic [3:0] be,
                                 output logic [31:0] wd, output wb_t e);
      bit ld, st, legal;
      int nb, off;
      logic [31:0] v, mask;
      ld    = (it == 3'd0);
      st    = (it == 3'd2);
      nb    = 1 << f3[1:0];
      off   = int'(a[1:0]);
      legal = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : st ? (f3 inside {3'd0, 3'd1, 3'd2}) : 1'b0;
      go    = legal && ((off % nb) == 0);
      be    = 4'(((1 << nb) - 1) << off);
      case (nb)
         1:       wd = sd[7:0] * 32'h01010101;
         2:       wd = sd[15:0] * 32'h00010001;
         default: wd = sd;
      endcase
      mask = (nb >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
      v    = (rdata >> (8 * off)) & mask;
      if (nb < 4 && f3 < 3'd4) begin
         if (v[8 * nb - 1]) v = v | ~mask;
      end
      e.cyc      = 0;
      e.rd       = r;
      e.err      = (ld || st) && !go;
      e.bt       = (it == 3'd6) && (((f3 == 3'd0) && z) || ((f3 == 3'd1) && !z));
      e.data     = (ld && go) ? v : a;
      e.we       = ((it == 3'd3) || (it == 3'd1) || (ld && go)) && (r != 5'd0);
      e.chk_data = 1'b1;
   endfunction

   // Called #1 after a rising edge with the unit idle; returns #1 after the unit is idle again.
   // d = wait cycles before mem_ready rises (d >= TO means it never does).
   task automatic send(input logic [2:0] it, input logic [2:0] f3, input logic [31:0] a, input logic z,
                       input logic [31:0] sd, input logic [4:0] r, input int d, input logic [31:0] rdata);
      bit go;
      logic [3:0] be;
      logic [31:0] wd;
      wb_t e;
      int n, k;
      itype = it; funct3 = f3; alu_out = a; zero = z; store_data = sd; rd = r; in_valid = 1'b1;
      model(it, f3, a, z, sd, r, rdata, go, be, wd, e);
      @(posedge clk); #1;
      n = cyc;
      in_valid = 1'b0;
      if (go) begin
         k = (d < TO) ? d + 1 : TO;
         if (d >= TO) begin
            e.err = 1'b1; e.we = 1'b0; e.chk_data = 1'b0;
         end
         acc_addr = {a[31:2], 2'b00}; acc_be = be; acc_wdata = wd; acc_we = (it == 3'd2);
         acc_s = n; acc_e = n + k;
         e.cyc = n + k;
         exp_q.push_back(e);
         for (int i = 0; i < k; i++) begin
            mem_ready = (i == d);
            mem_rdata = (i == d) ? rdata : $urandom;
            in_valid  = 1'($urandom_range(0, 1));
            itype     = 3'($urandom);
            funct3    = 3'($urandom);
            alu_out   = $urandom;
            rd        = 5'($urandom);
            @(posedge clk); #1;
         end
         mem_ready = 1'b0;
         in_valid  = 1'b0;
      end else begin
         e.cyc = n;
         exp_q.push_back(e);
      end
   endtask

   task automatic settle();
      repeat (TO + 3) @(posedge clk);
      #1;
   endtask

   function automatic wb_t last_obs();
      wb_t o;
      o = '{default: 0};
      if (obs_q.size() > 0) o = obs_q[obs_q.size() - 1];
      return o;
   endfunction

   always @(negedge clk) begin
      if (!reset_n) begin
         check("rst_mem_req", mem_req, 1'b0);
         check("rst_in_ready", in_ready, 1'b1);
         check("rst_wb_valid", wb_valid, 1'b0);
         check("rst_wb_err", wb_err, 1'b0);
         check("rst_wb_data", wb_data, 32'h0);
         last_data = '0; last_rd = '0; hold_known = 1'b1; req_run = 0;
      end else begin
         exp_req = (cyc >= acc_s) && (cyc < acc_e);
         check("mem_req", mem_req, exp_req);
         check("in_ready", in_ready, !exp_req);
         if (exp_req) begin
            check("mem_we", mem_we, acc_we);
            check("mem_addr", mem_addr, acc_addr);
            check("mem_be", mem_be, acc_be);
            check("mem_wdata", mem_wdata, acc_wdata);
         end
         if (mem_req) begin
            req_run++; req_total++;
            obs_addr = mem_addr; obs_be = mem_be; obs_wdata = mem_wdata; obs_mwe = mem_we;
         end else if (req_run != 0) begin
            req_cycles = req_run; req_run = 0;
         end
         if (wb_valid) begin
            co.cyc = cyc; co.data = wb_data; co.rd = wb_rd; co.we = wb_we;
            co.err = wb_err; co.bt = branch_taken; co.chk_data = 1'b1;
            obs_q.push_back(co);
         end
         if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
            ce = exp_q.pop_front();
            check("wb_valid", wb_valid, 1'b1);
            check("wb_we", wb_we, ce.we);
            check("wb_err", wb_err, ce.err);
            check("branch_taken", branch_taken, ce.bt);
            if (ce.chk_data) begin
               check("wb_data", wb_data, ce.data);
               check("wb_rd", wb_rd, ce.rd);
               last_data = ce.data; last_rd = ce.rd; hold_known = 1'b1;
            end else begin
               hold_known = 1'b0;
            end
         end else begin
            check("wb_valid_idle", wb_valid, 1'b0);
            check("wb_we_idle", wb_we, 1'b0);
            check("wb_err_idle", wb_err, 1'b0);
            check("branch_taken_idle", branch_taken, 1'b0);
            if (hold_known) begin
               check("wb_data_hold", wb_data, last_data);
               check("wb_rd_hold", wb_rd, last_rd);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   logic [2:0] it_tab [10] = '{3'd0, 3'd0, 3'd0, 3'd2, 3'd2, 3'd3, 3'd1, 3'd6, 3'd4, 3'd7};

   initial begin
      int base, r0;
      logic [2:0] it, f3;
      logic [31:0] a;
      logic [4:0] r;
      reset_n = 1'b0; in_valid = 1'b0; itype = '0; funct3 = '0; alu_out = '0; zero = 1'b0;
      store_data = '0; rd = '0; mem_rdata = '0; mem_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_in_ready", in_ready, 1'b1);
      check("reset_mem_req", mem_req, 1'b0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Back-to-back register packets.
      base = obs_q.size();
      send(3'b011, 3'd0, 32'h5, 1'b0, 32'h0, 5'd3, 0, 32'h0);
      send(3'b011, 3'd0, 32'h6, 1'b0, 32'h0, 5'd4, 0, 32'h0);
      send(3'b001, 3'd0, 32'h7, 1'b0, 32'h0, 5'd0, 0, 32'h0);
      settle();
      check("rtype_pulse_count", obs_q.size() - base, 3);
      if (obs_q.size() >= base + 3) begin
         check("rtype_data", obs_q[base].data, 32'h5);
         check("rtype_we", obs_q[base].we, 1'b1);
         check("rtype_rd", obs_q[base].rd, 5'd3);
         check("b2b_gap_1", obs_q[base + 1].cyc - obs_q[base].cyc, 1);
         check("b2b_gap_2", obs_q[base + 2].cyc - obs_q[base + 1].cyc, 1);
         check("rd0_no_we", obs_q[base + 2].we, 1'b0);
      end

      // LB / LBU at 0x103 after 3 wait cycles.
      send(3'b000, 3'b000, 32'h103, 1'b0, 32'h0, 5'd5, 3, 32'h80FF1234);
      settle();
      check("lb_addr", obs_addr, 32'h100);
      check("lb_be", obs_be, 4'b1000);
      check("lb_req_cycles", req_cycles, 4);
      check("lb_data", last_obs().data, 32'hFFFFFF80);
      send(3'b000, 3'b100, 32'h103, 1'b0, 32'h0, 5'd5, 3, 32'h80FF1234);
      settle();
      check("lbu_data", last_obs().data, 32'h00000080);

      // SH at 0x202.
      send(3'b010, 3'b001, 32'h202, 1'b0, 32'h0000BEEF, 5'd7, 1, 32'h0);
      settle();
      check("sh_we", obs_mwe, 1'b1);
      check("sh_be", obs_be, 4'b1100);
      check("sh_wdata", obs_wdata, 32'hBEEFBEEF);
      check("sh_wb_we", last_obs().we, 1'b0);

      // Misaligned LW and illegal store funct3.
      r0 = req_total;
      send(3'b000, 3'b010, 32'h101, 1'b0, 32'h0, 5'd9, 0, 32'h0);
      settle();
      check("lw_misaligned_err", last_obs().err, 1'b1);
      send(3'b010, 3'b011, 32'h200, 1'b0, 32'h1234, 5'd9, 0, 32'h0);
      settle();
      check("sw_illegal_err", last_obs().err, 1'b1);
      check("rejected_no_req", req_total - r0, 0);

      // Timeout, then ready on the last permitted cycle.
      send(3'b000, 3'b010, 32'h40, 1'b0, 32'h0, 5'd10, 50, 32'h0);
      settle();
      check("timeout_req_cycles", req_cycles, TO);
      check("timeout_err", last_obs().err, 1'b1);
      check("timeout_we", last_obs().we, 1'b0);
      send(3'b000, 3'b010, 32'h44, 1'b0, 32'h0, 5'd10, TO - 1, 32'h12345678);
      settle();
      check("late_ready_req_cycles", req_cycles, TO);
      check("late_ready_err", last_obs().err, 1'b0);
      check("late_ready_data", last_obs().data, 32'h12345678);

      // BNE not-equal.
      send(3'b110, 3'b001, 32'h88, 1'b0, 32'h0, 5'd2, 0, 32'h0);
      settle();
      check("bne_taken", last_obs().bt, 1'b1);
      check("bne_we", last_obs().we, 1'b0);

      // Reset pulsed during ACCESS.
      itype = 3'b000; funct3 = 3'b010; alu_out = 32'h80; store_data = 32'h0; rd = 5'd1;
      in_valid = 1'b1; mem_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      acc_addr = 32'h80; acc_be = 4'hF; acc_wdata = 32'h0; acc_we = 1'b0;
      acc_s = cyc; acc_e = cyc + 1000;
      @(posedge clk); #1;
      reset_n = 1'b0;
      acc_s = -1; acc_e = -1;
      #1;
      check("reset_drops_req", mem_req, 1'b0);
      check("reset_ready_now", in_ready, 1'b1);
      base = obs_q.size();
      @(posedge clk); #1;
      reset_n = 1'b1;
      settle();
      check("reset_no_wb", obs_q.size() - base, 0);
      check("ready_after_reset", in_ready, 1'b1);

      // Randomized traffic.
      for (int n = 0; n < 300; n++) begin
         it = it_tab[$urandom_range(0, 9)];
         f3 = 3'($urandom);
         if (it == 3'd6 && $urandom_range(0, 1) == 1) f3 = 3'($urandom_range(0, 1));
         a = $urandom;
         if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         r = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         send(it, f3, a, 1'($urandom), $urandom, r, $urandom_range(0, TO + 1), $urandom);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
      end
      settle();
      check("model_queue_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
